// File: rtl/rom_scan_accum.sv
// rom_scan_accum: walks a small combinational ROM from address 0 up to
// LAST_ADDR, offers each word downstream through a valid/ready register
// slice, and keeps a running sum and maximum of the words captured.
module rom_scan_accum #(
  parameter int unsigned LAST_ADDR = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [2:0] rom_addr,
  input  logic [5:0] rom_data,
  output logic [5:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done,
  output logic [8:0] sum,
  output logic [5:0] max_val
);

  // Final scan address, narrowed to the ROM address width.
  localparam logic [2:0] LAST_A = 3'(LAST_ADDR);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e     state_q;
  logic [2:0] addr_q;
  logic [5:0] data_q;
  logic       valid_q;
  logic       busy_q;
  logic       done_q;
  logic [8:0] sum_q;
  logic [5:0] max_q;

  logic       capture_s;
  logic       release_s;
  logic       last_s;
  logic [8:0] sum_d;
  logic [5:0] max_d;
  logic [2:0] addr_d;

  // Capture/release qualifiers and the accumulator next values.
  always_comb begin
    capture_s = 1'b0;
    release_s = 1'b0;
    last_s    = 1'b0;
    sum_d     = sum_q;
    max_d     = max_q;
    addr_d    = addr_q;
    // The output slot is free when it is empty or being drained this cycle.
    capture_s = (~valid_q) | out_ready;
    release_s = (~valid_q) | out_ready;
    last_s    = (addr_q == LAST_A);
    sum_d     = sum_q + {3'b000, rom_data};
    if (rom_data > max_q) begin
      max_d = rom_data;
    end else begin
      max_d = max_q;
    end
    // Address saturates at the last entry so it never wraps past the scan.
    if (last_s) begin
      addr_d = addr_q;
    end else begin
      addr_d = addr_q + 3'd1;
    end
  end

  // Scan controller: state, output slice and accumulators, all registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= 3'd0;
      data_q  <= 6'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= 9'd0;
      max_q   <= 6'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            addr_q  <= 3'd0;
            sum_q   <= 9'd0;
            max_q   <= 6'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          // Without a capture the slot holds its word and everything stalls.
          if (capture_s) begin
            data_q  <= rom_data;
            valid_q <= 1'b1;
            sum_q   <= sum_d;
            max_q   <= max_d;
            addr_q  <= addr_d;
            if (last_s) begin
              state_q <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // Completion is withheld until the final word has left the slot.
          if (release_s) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          // One-cycle completion pulse; start is not sampled here.
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rom_addr  = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign max_val   = max_q;

endmodule

// File: tb/tb_rom_scan_accum.sv
// Directed bench for rom_scan_accum: a square-law ROM on the main instance
// and a constant-63 ROM on a single-address instance.
module tb_rom_scan_accum;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic       out_ready;
  logic [2:0] rom_addr;
  logic [5:0] rom_data;
  logic [5:0] addr6;
  logic [5:0] out_data;
  logic       out_valid;
  logic       busy;
  logic       done;
  logic [8:0] sum;
  logic [5:0] max_val;

  logic       start0;
  logic       out_ready0;
  logic [2:0] rom_addr0;
  logic [5:0] rom_data0;
  logic [5:0] out_data0;
  logic       out_valid0;
  logic       busy0;
  logic       done0;
  logic [8:0] sum0;
  logic [5:0] max_val0;

  // ROM models: addr*addr for the main instance, constant 63 for the other.
  assign addr6     = {3'b000, rom_addr};
  assign rom_data  = addr6 * addr6;
  assign rom_data0 = 6'd63;

  rom_scan_accum #(.LAST_ADDR(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rom_addr(rom_addr),
    .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .sum(sum),
    .max_val(max_val)
  );

  rom_scan_accum #(.LAST_ADDR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .rom_addr(rom_addr0),
    .rom_data(rom_data0), .out_data(out_data0), .out_valid(out_valid0),
    .out_ready(out_ready0), .busy(busy0), .done(done0), .sum(sum0),
    .max_val(max_val0)
  );

  typedef struct {
    logic       st;
    logic       rdy;
    logic       vld;
    logic [5:0] dat;
    logic [2:0] adr;
    logic [8:0] sm;
    logic [5:0] mx;
    logic       bsy;
    logic       dn;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic st, input logic rdy, input logic vld,
                             input int dat, input int adr, input int sm,
                             input int mx, input logic bsy, input logic dn);
    vec_t r;
    r.st  = st;
    r.rdy = rdy;
    r.vld = vld;
    r.dat = 6'(dat);
    r.adr = 3'(adr);
    r.sm  = 9'(sm);
    r.mx  = 6'(mx);
    r.bsy = bsy;
    r.dn  = dn;
    return r;
  endfunction

  // Rows 1..8 of an uninterrupted scan (after the start row).
  task automatic push_full_scan_body();
    tbl.push_back(v(0, 1, 1,  0, 1,   0,  0, 1, 0));
    tbl.push_back(v(0, 1, 1,  1, 2,   1,  1, 1, 0));
    tbl.push_back(v(0, 1, 1,  4, 3,   5,  4, 1, 0));
    tbl.push_back(v(0, 1, 1,  9, 4,  14,  9, 1, 0));
    tbl.push_back(v(0, 1, 1, 16, 5,  30, 16, 1, 0));
    tbl.push_back(v(0, 1, 1, 25, 6,  55, 25, 1, 0));
    tbl.push_back(v(0, 1, 1, 36, 7,  91, 36, 1, 0));
    tbl.push_back(v(0, 1, 1, 49, 7, 140, 49, 1, 0));
  endtask

  task automatic wait_done(input string nm, input int limit);
    int n;
    n = 0;
    while (done !== 1'b1 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int dn_cnt;
    rst_n      = 1'b0;
    start      = 1'b0;
    out_ready  = 1'b1;
    start0     = 1'b0;
    out_ready0 = 1'b1;
    #3;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset busy",      32'(busy),      32'd0);
    chk("reset done",      32'(done),      32'd0);
    chk("reset sum",       32'(sum),       32'd0);
    chk("reset rom_addr",  32'(rom_addr),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle no-start busy", 32'(busy),     32'd0);
    chk("idle no-start addr", 32'(rom_addr), 32'd0);

    // Single-address scan of a constant-63 ROM.
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    chk("l0 busy",        32'(busy0),      32'd1);
    chk("l0 valid_early", 32'(out_valid0), 32'd0);
    @(posedge clk); #1;
    chk("l0 valid", 32'(out_valid0), 32'd1);
    chk("l0 data",  32'(out_data0),  32'd63);
    chk("l0 sum",   32'(sum0),       32'd63);
    chk("l0 max",   32'(max_val0),   32'd63);
    chk("l0 addr",  32'(rom_addr0),  32'd0);
    @(posedge clk); #1;
    chk("l0 done",       32'(done0),      32'd1);
    chk("l0 valid_drn",  32'(out_valid0), 32'd0);
    @(posedge clk); #1;
    chk("l0 done_end", 32'(done0), 32'd0);
    chk("l0 busy_end", 32'(busy0), 32'd0);
    chk("l0 sum_hold", 32'(sum0),  32'd63);

    // Table: full scan, scan with a 3-cycle stall after word 9, scan with
    // out_ready low for 5 cycles in DRAIN.
    tbl.push_back(v(1, 1, 0,  0, 0,   0,  0, 1, 0));
    push_full_scan_body();
    tbl.push_back(v(0, 1, 0, 49, 7, 140, 49, 0, 1));
    tbl.push_back(v(0, 1, 0, 49, 7, 140, 49, 0, 0));
    tbl.push_back(v(0, 0, 0, 49, 7, 140, 49, 0, 0));

    tbl.push_back(v(1, 1, 0, 49, 0,   0,  0, 1, 0));
    tbl.push_back(v(0, 1, 1,  0, 1,   0,  0, 1, 0));
    tbl.push_back(v(0, 1, 1,  1, 2,   1,  1, 1, 0));
    tbl.push_back(v(0, 1, 1,  4, 3,   5,  4, 1, 0));
    tbl.push_back(v(0, 1, 1,  9, 4,  14,  9, 1, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 0, 1, 9, 4, 14, 9, 1, 0));
    tbl.push_back(v(0, 1, 1, 16, 5,  30, 16, 1, 0));
    tbl.push_back(v(0, 1, 1, 25, 6,  55, 25, 1, 0));
    tbl.push_back(v(0, 1, 1, 36, 7,  91, 36, 1, 0));
    tbl.push_back(v(0, 1, 1, 49, 7, 140, 49, 1, 0));
    tbl.push_back(v(0, 1, 0, 49, 7, 140, 49, 0, 1));
    tbl.push_back(v(0, 1, 0, 49, 7, 140, 49, 0, 0));

    tbl.push_back(v(1, 1, 0, 49, 0,   0,  0, 1, 0));
    push_full_scan_body();
    for (int k = 0; k < 5; k++) tbl.push_back(v(0, 0, 1, 49, 7, 140, 49, 1, 0));
    tbl.push_back(v(0, 1, 0, 49, 7, 140, 49, 0, 1));
    tbl.push_back(v(0, 1, 0, 49, 7, 140, 49, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      start     = tbl[i].st;
      out_ready = tbl[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].vld));
      chk($sformatf("row%0d out_data", i),  32'(out_data),  32'(tbl[i].dat));
      chk($sformatf("row%0d rom_addr", i),  32'(rom_addr),  32'(tbl[i].adr));
      chk($sformatf("row%0d sum", i),       32'(sum),       32'(tbl[i].sm));
      chk($sformatf("row%0d max_val", i),   32'(max_val),   32'(tbl[i].mx));
      chk($sformatf("row%0d busy", i),      32'(busy),      32'(tbl[i].bsy));
      chk($sformatf("row%0d done", i),      32'(done),      32'(tbl[i].dn));
    end
    start     = 1'b0;
    out_ready = 1'b1;

    // start held high: one scan, DONE ignores start, rescan only from IDLE.
    start  = 1'b1;
    dn_cnt = 0;
    for (int c = 0; c < 11; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dn_cnt++;
    end
    chk("held done_count", 32'(dn_cnt), 32'd1);
    chk("held idle_busy",  32'(busy),   32'd0);
    chk("held idle_done",  32'(done),   32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("held rescan busy", 32'(busy),     32'd1);
    chk("held rescan addr", 32'(rom_addr), 32'd0);
    chk("held rescan sum",  32'(sum),      32'd0);
    wait_done("held second done", 20);
    chk("held second sum", 32'(sum),     32'd140);
    chk("held second max", 32'(max_val), 32'd49);
    @(posedge clk); #1;
    chk("held back idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of a scan at address 5.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst pre addr", 32'(rom_addr), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("rst async addr",  32'(rom_addr),  32'd0);
    chk("rst async data",  32'(out_data),  32'd0);
    chk("rst async valid", 32'(out_valid), 32'd0);
    chk("rst async busy",  32'(busy),      32'd0);
    chk("rst async done",  32'(done),      32'd0);
    chk("rst async sum",   32'(sum),       32'd0);
    chk("rst async max",   32'(max_val),   32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst stay idle busy", 32'(busy),      32'd0);
    chk("rst stay idle vld",  32'(out_valid), 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rst rescan addr", 32'(rom_addr), 32'd0);
    chk("rst rescan busy", 32'(busy),     32'd1);
    @(posedge clk); #1;
    chk("rst rescan word0", 32'(out_data), 32'd0);
    chk("rst rescan addr1", 32'(rom_addr), 32'd1);
    chk("rst rescan sum0",  32'(sum),      32'd0);
    wait_done("rst rescan done", 20);
    chk("rst rescan sum", 32'(sum), 32'd140);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_scan_accum.md
ROM_SCAN_ACCUM -- requirements
Module: rom_scan_accum

Interface
REQ-001 Parameter LAST_ADDR, default 7, SHALL give the final address of a scan (0..7).
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL be a scan request, sampled only in IDLE.
REQ-005 rom_addr  output  3  SHALL drive the address {a,b,c} of the downstream combinational ROM (a = bit 2).
REQ-006 rom_data  input  6  SHALL carry the ROM word {b5..b0} for rom_addr, valid in the same cycle.
REQ-007 out_data  output  6  SHALL be the registered ROM word offered downstream.
REQ-008 out_valid  output  1  SHALL be high while out_data holds an unconsumed word.
REQ-009 out_ready  input  1  SHALL be the downstream acceptance; a transfer occurs when out_valid and out_ready are both high.
REQ-010 busy  output  1  SHALL be high in SCAN and DRAIN.
REQ-011 done  output  1  SHALL pulse high for exactly one cycle at scan completion.
REQ-012 sum  output  9  SHALL hold the running sum of all captured words (max 8*63 = 504, no overflow).
REQ-013 max_val  output  6  SHALL hold the largest captured word of the current scan.

Function
REQ-014 The FSM SHALL have states IDLE, SCAN, DRAIN, DONE.
REQ-015 IDLE: start=1 SHALL clear sum, max_val and rom_addr to 0 and enter SCAN next cycle; start=0 SHALL hold.
REQ-016 SCAN: capture SHALL occur in a cycle where out_valid=0 or (out_valid & out_ready)=1.
REQ-017 On capture: out_data <= rom_data, out_valid <= 1, sum <= sum + rom_data, max_val <= max(max_val, rom_data), rom_addr <= rom_addr + 1.
REQ-018 Without capture (out_valid=1, out_ready=0): rom_addr, out_data, sum, max_val SHALL hold (stall).
REQ-019 A capture at rom_addr = LAST_ADDR SHALL enter DRAIN and SHALL leave rom_addr at LAST_ADDR (no wrap).
REQ-020 A transfer without simultaneous capture SHALL clear out_valid.
REQ-021 DRAIN: SHALL wait until out_valid=0 or a transfer occurs, then clear out_valid and enter DONE.
REQ-022 DONE: done SHALL be 1 for this single cycle; next state SHALL be IDLE; sum and max_val SHALL persist until the next start.
REQ-023 start asserted outside IDLE (including in DONE) SHALL be ignored.
REQ-024 With out_ready held high, a scan SHALL take LAST_ADDR+1 SCAN cycles, one DRAIN cycle, one DONE cycle; first out_valid one cycle after entering SCAN.
REQ-025 LAST_ADDR = 0 SHALL perform a single capture of address 0.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, rom_addr=0, out_data=0, out_valid=0, busy=0, done=0, sum=0, max_val=0, including mid-scan.
REQ-027 After rst_n release, no scan SHALL begin until a new start is sampled in IDLE.

Verification
REQ-028 ROM model returns addr*addr; start pulse, out_ready=1 -> words 0,1,4,9,16,25,36,49 in order, sum=140, max_val=49, done one cycle, 10 cycles SCAN..DONE.
REQ-029 Same, out_ready low for 3 cycles after word 9 -> out_data holds 9, rom_addr holds 4, sum holds 14; sequence resumes intact, final sum=140.
REQ-030 start held high through whole scan -> exactly one scan, done pulses once, returns to IDLE, then second scan starts only after IDLE.
REQ-031 rst_n low while rom_addr=5 -> all outputs 0 asynchronously; next start rescans from address 0 with sum restarting at 0.
REQ-032 LAST_ADDR=0, ROM model constant 63 -> one word 63, sum=63, max_val=63, done asserted.
REQ-033 out_ready low through DRAIN for 5 cycles -> done withheld until final word accepted, then pulses exactly once.
